// File: rtl/vanilla_sb_tracker_pkg.sv
// vanilla_sb_tracker_pkg: latency categories, sample record and issue classifier
// shared by the remote scoreboard tracker and its per-register entries.
package vanilla_sb_tracker_pkg;

    localparam int cat_w_gp        = 6;
    localparam int sample_idx_w_gp = 8;
    localparam int sample_age_w_gp = 32;

    typedef enum logic [2:0] {
        LONG_OP       = 3'd0,
        DRAM_LOAD     = 3'd1,
        DRAM_SEQ_LOAD = 3'd2,
        DRAM_AMO      = 3'd3,
        GLOBAL_LOAD   = 3'd4,
        GROUP_LOAD    = 3'd5
    } sb_cat_e;

    // Fields are sized for the widest supported configuration; the top slices them down.
    typedef struct packed {
        logic [sample_idx_w_gp-1:0] rf;
        logic [sample_idx_w_gp-1:0] rd;
        logic [cat_w_gp-1:0]        cat;
        logic [sample_age_w_gp-1:0] age;
    } vanilla_sb_sample_s;

    // One-hot category for an instruction leaving ID; zero when untracked.
    function automatic logic [cat_w_gp-1:0] sb_classify(
        input logic       is_long,
        input logic       is_load,
        input logic       is_amo,
        input logic       is_seq,
        input logic [2:0] top
    );
        logic [cat_w_gp-1:0] c;
        c = '0;
        if (is_long)
            c[LONG_OP] = 1'b1;
        else if (is_load && top[2])
            c[is_seq ? DRAM_SEQ_LOAD : DRAM_LOAD] = 1'b1;
        else if (is_amo && top[2])
            c[DRAM_AMO] = 1'b1;
        else if (is_load && top[2:1] == 2'b01)
            c[GLOBAL_LOAD] = 1'b1;
        else if (is_load && top == 3'b001)
            c[GROUP_LOAD] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/vanilla_sb_entry.sv
// vanilla_sb_entry: pending category mask and saturating age for one register.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   set, set_cat     : new pending category (OR'd into the mask)
//   clr              : drop the current contents (applied before set)
//   mask, age        : pending categories and cycles pending
module vanilla_sb_entry
    import vanilla_sb_tracker_pkg::*;
#(
    parameter int age_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   set,
    input  logic [cat_w_gp-1:0]    set_cat,
    input  logic                   clr,
    output logic [cat_w_gp-1:0]    mask,
    output logic [age_width_p-1:0] age
);

    // A fresh set (empty or just-cleared entry) starts at age 0; a set onto a
    // still-pending entry keeps counting.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mask <= '0;
            age  <= '0;
        end else begin
            mask <= (clr ? '0 : mask) | (set ? set_cat : '0);
            age  <= (clr || mask == '0) ? '0 : (&age ? age : age + 1'b1);
        end
    end

endmodule

// File: rtl/vanilla_remote_sb_tracker.sv
// vanilla_remote_sb_tracker: per-register long-latency scoreboard for profiling.
//   issue_*   : instruction leaving ID, classified into one category
//   clear_*   : writeback clears, one per port
//   sb_o      : pending category mask per register, outstanding_o : pending count per rf
//   sample_*  : registered latency sample per clear port, err_o : sticky protocol error
module vanilla_remote_sb_tracker
    import vanilla_sb_tracker_pkg::*;
#(
    parameter int data_width_p      = 32,
    parameter int reg_els_p         = 32,
    parameter int num_rf_p          = 2,
    parameter int num_clear_ports_p = 2,
    parameter int age_width_p       = 16,
    localparam int rf_w  = num_rf_p > 1 ? $clog2(num_rf_p) : 1,
    localparam int rd_w  = reg_els_p > 1 ? $clog2(reg_els_p) : 1,
    localparam int cnt_w = $clog2(reg_els_p + 1)
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_n_i,
    input  logic                                                 stall_all_i,
    input  logic                                                 stall_id_i,
    input  logic                                                 flush_i,
    input  logic                                                 issue_v_i,
    input  logic [rf_w-1:0]                                      issue_rf_i,
    input  logic [rd_w-1:0]                                      issue_rd_i,
    input  logic                                                 issue_is_long_i,
    input  logic                                                 issue_is_load_i,
    input  logic                                                 issue_is_amo_i,
    input  logic                                                 issue_is_seq_i,
    input  logic [data_width_p-1:0]                              issue_addr_i,
    input  logic [num_clear_ports_p-1:0]                         clear_v_i,
    input  logic [num_clear_ports_p-1:0][rf_w-1:0]               clear_rf_i,
    input  logic [num_clear_ports_p-1:0][rd_w-1:0]               clear_id_i,
    output logic [num_rf_p-1:0][reg_els_p-1:0][cat_w_gp-1:0]     sb_o,
    output logic [num_rf_p-1:0][cnt_w-1:0]                       outstanding_o,
    output logic [num_clear_ports_p-1:0]                         sample_v_o,
    output logic [num_clear_ports_p-1:0][rf_w-1:0]               sample_rf_o,
    output logic [num_clear_ports_p-1:0][rd_w-1:0]               sample_rd_o,
    output logic [num_clear_ports_p-1:0][cat_w_gp-1:0]           sample_cat_o,
    output logic [num_clear_ports_p-1:0][age_width_p-1:0]        sample_age_o,
    output logic                                                 err_o
);

    logic                                                 advance;
    logic [cat_w_gp-1:0]                                  cat;
    logic [num_rf_p-1:0][reg_els_p-1:0]                   set;
    logic [num_rf_p-1:0][reg_els_p-1:0]                   clr;
    logic [num_rf_p-1:0][reg_els_p-1:0][age_width_p-1:0]  age;
    logic [num_clear_ports_p-1:0]                         hit;
    logic [num_clear_ports_p-1:0]                         dup;
    logic                                                 pend_err;
    vanilla_sb_sample_s [num_clear_ports_p-1:0]           smp;
    vanilla_sb_sample_s [num_clear_ports_p-1:0]           smp_q;
    logic [num_rf_p-1:0][cnt_w-1:0]                       cnt;
    logic                                                 unused;

    assign advance = issue_v_i & ~stall_id_i & ~stall_all_i & ~flush_i;
    assign cat     = sb_classify(issue_is_long_i, issue_is_load_i, issue_is_amo_i,
                                 issue_is_seq_i, issue_addr_i[data_width_p-1 -: 3]);
    assign unused  = ^{issue_addr_i[data_width_p-4:0], smp_q};

    // Clear decode: a port only "hits" a pending entry; a later port hitting an
    // entry already claimed by a lower port is a duplicate and does not sample.
    // Sample age counts the clearing cycle, so it equals the cycles the mask was visible.
    always_comb begin
        set      = '0;
        clr      = '0;
        hit      = '0;
        dup      = '0;
        smp      = '0;
        pend_err = 1'b0;
        for (int p = 0; p < num_clear_ports_p; p++) begin
            for (int r = 0; r < num_rf_p; r++) begin
                for (int e = 0; e < reg_els_p; e++) begin
                    if (clear_v_i[p] && clear_rf_i[p] == rf_w'(r) && clear_id_i[p] == rd_w'(e)
                        && sb_o[r][e] != '0) begin
                        hit[p]      = 1'b1;
                        clr[r][e]   = 1'b1;
                        smp[p].rf   = sample_idx_w_gp'(clear_rf_i[p]);
                        smp[p].rd   = sample_idx_w_gp'(clear_id_i[p]);
                        smp[p].cat  = sb_o[r][e];
                        smp[p].age  = sample_age_w_gp'(&age[r][e] ? age[r][e] : age[r][e] + 1'b1);
                    end
                end
            end
            for (int q = 0; q < p; q++)
                if (hit[q] && clear_rf_i[q] == clear_rf_i[p] && clear_id_i[q] == clear_id_i[p])
                    dup[p] = 1'b1;
        end
        for (int r = 0; r < num_rf_p; r++) begin
            for (int e = 0; e < reg_els_p; e++) begin
                set[r][e] = advance && cat != '0 && issue_rf_i == rf_w'(r) && issue_rd_i == rd_w'(e);
                if (set[r][e] && sb_o[r][e] != '0 && !clr[r][e])
                    pend_err = 1'b1;
            end
        end
    end

    for (genvar r = 0; r < num_rf_p; r++) begin : g_rf
        for (genvar e = 0; e < reg_els_p; e++) begin : g_el
            vanilla_sb_entry #(.age_width_p(age_width_p)) u_entry (
                .clk_i     (clk_i),
                .reset_n_i (reset_n_i),
                .set       (set[r][e]),
                .set_cat   (cat),
                .clr       (clr[r][e]),
                .mask      (sb_o[r][e]),
                .age       (age[r][e])
            );
        end
    end

    always_comb begin
        cnt = '0;
        for (int r = 0; r < num_rf_p; r++)
            for (int e = 0; e < reg_els_p; e++)
                cnt[r] = cnt[r] + cnt_w'(sb_o[r][e] != '0);
    end

    assign outstanding_o = cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sample_v_o <= '0;
            err_o      <= 1'b0;
        end else begin
            sample_v_o <= hit & ~dup;
            err_o      <= err_o | (|dup) | pend_err;
        end
        smp_q <= smp;
    end

    always_comb begin
        sample_rf_o  = '0;
        sample_rd_o  = '0;
        sample_cat_o = '0;
        sample_age_o = '0;
        for (int p = 0; p < num_clear_ports_p; p++) begin
            sample_rf_o[p]  = smp_q[p].rf[rf_w-1:0];
            sample_rd_o[p]  = smp_q[p].rd[rd_w-1:0];
            sample_cat_o[p] = smp_q[p].cat;
            sample_age_o[p] = smp_q[p].age[age_width_p-1:0];
        end
    end

endmodule

// File: tb/tb_vanilla_remote_sb_tracker.sv
// tb_vanilla_remote_sb_tracker: directed and random stimulus against a behavioural scoreboard model.
module tb_vanilla_remote_sb_tracker;
    localparam int NRF = 2, NREG = 32, NP = 2;

    logic clk = 1'b0;
    logic reset_n, stall_all, stall_id, flush, issue_v;
    logic [0:0] issue_rf;
    logic [4:0] issue_rd;
    logic is_long, is_load, is_amo, is_seq;
    logic [31:0] addr;
    logic [NP-1:0] clear_v;
    logic [NP-1:0][0:0] clear_rf;
    logic [NP-1:0][4:0] clear_id;

    logic [NRF-1:0][NREG-1:0][5:0] sb, sb4;
    logic [NRF-1:0][5:0] outstanding, out4;
    logic [NP-1:0] sv, sv4;
    logic [NP-1:0][0:0] srf, srf4;
    logic [NP-1:0][4:0] srd, srd4;
    logic [NP-1:0][5:0] scat, scat4;
    logic [NP-1:0][15:0] sage;
    logic [NP-1:0][3:0] sage4;
    logic err, err4;

    int vectors = 0, miscompares = 0;
    int m_cat[NRF][NREG];
    int m_age[NRF][NREG];
    bit m_err;
    logic [NP-1:0] e_sv;
    int e_rf[NP], e_rd[NP], e_cat[NP], e_age[NP];

    always #5 clk = ~clk;

    vanilla_remote_sb_tracker #(.data_width_p(32), .reg_els_p(NREG), .num_rf_p(NRF),
        .num_clear_ports_p(NP), .age_width_p(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .stall_all_i(stall_all), .stall_id_i(stall_id),
        .flush_i(flush), .issue_v_i(issue_v), .issue_rf_i(issue_rf), .issue_rd_i(issue_rd),
        .issue_is_long_i(is_long), .issue_is_load_i(is_load), .issue_is_amo_i(is_amo),
        .issue_is_seq_i(is_seq), .issue_addr_i(addr), .clear_v_i(clear_v), .clear_rf_i(clear_rf),
        .clear_id_i(clear_id), .sb_o(sb), .outstanding_o(outstanding), .sample_v_o(sv),
        .sample_rf_o(srf), .sample_rd_o(srd), .sample_cat_o(scat), .sample_age_o(sage), .err_o(err));

    vanilla_remote_sb_tracker #(.data_width_p(32), .reg_els_p(NREG), .num_rf_p(NRF),
        .num_clear_ports_p(NP), .age_width_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .stall_all_i(stall_all), .stall_id_i(stall_id),
        .flush_i(flush), .issue_v_i(issue_v), .issue_rf_i(issue_rf), .issue_rd_i(issue_rd),
        .issue_is_long_i(is_long), .issue_is_load_i(is_load), .issue_is_amo_i(is_amo),
        .issue_is_seq_i(is_seq), .issue_addr_i(addr), .clear_v_i(clear_v), .clear_rf_i(clear_rf),
        .clear_id_i(clear_id), .sb_o(sb4), .outstanding_o(out4), .sample_v_o(sv4),
        .sample_rf_o(srf4), .sample_rd_o(srd4), .sample_cat_o(scat4), .sample_age_o(sage4), .err_o(err4));

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Category value as a bit mask: long=1, dram=2, dram_seq=4, amo=8, global=16, group=32.
    function automatic int model_cat();
        int top = int'(addr[31:29]);
        if (is_long) return 1;
        if (is_load && top >= 4) return is_seq ? 4 : 2;
        if (is_amo && top >= 4) return 8;
        if (is_load && top >= 2) return 16;
        if (is_load && top == 1) return 32;
        return 0;
    endfunction

    // Applies the current inputs to the model as the upcoming clock edge would.
    task automatic step_model();
        bit cleared[NRF][NREG];
        int nc[NRF][NREG];
        int na[NRF][NREG];
        int c, r, i;
        e_sv = '0;
        for (int a = 0; a < NRF; a++)
            for (int b = 0; b < NREG; b++) begin
                cleared[a][b] = 1'b0;
                nc[a][b] = reset_n ? m_cat[a][b] : 0;
                na[a][b] = 0;
            end
        if (!reset_n) begin
            m_err = 1'b0;
            m_cat = nc;
            m_age = na;
            return;
        end
        for (int p = 0; p < NP; p++) begin
            r = int'(clear_rf[p]);
            i = int'(clear_id[p]);
            if (clear_v[p] && m_cat[r][i] != 0) begin
                if (cleared[r][i]) m_err = 1'b1;
                else begin
                    e_sv[p] = 1'b1;
                    e_rf[p] = r;
                    e_rd[p] = i;
                    e_cat[p] = m_cat[r][i];
                    e_age[p] = m_age[r][i] + 1;
                    cleared[r][i] = 1'b1;
                    nc[r][i] = 0;
                end
            end
        end
        for (int a = 0; a < NRF; a++)
            for (int b = 0; b < NREG; b++)
                if (nc[a][b] != 0) na[a][b] = m_age[a][b] + 1;
        c = model_cat();
        if (issue_v && !stall_id && !stall_all && !flush && c != 0) begin
            r = int'(issue_rf);
            i = int'(issue_rd);
            if (nc[r][i] == 0) begin
                nc[r][i] = c;
                na[r][i] = 0;
            end else begin
                nc[r][i] = nc[r][i] | c;
                m_err = 1'b1;
            end
        end
        m_cat = nc;
        m_age = na;
    endtask

    task automatic compare();
        logic [511:0] esb;
        int n;
        esb = '0;
        for (int r = 0; r < NRF; r++)
            for (int i = 0; i < NREG; i++) esb[(r*NREG+i)*6 +: 6] = 6'(m_cat[r][i]);
        chk("sb", 512'(sb), esb);
        chk("sb_age4", 512'(sb4), esb);
        for (int r = 0; r < NRF; r++) begin
            n = 0;
            for (int i = 0; i < NREG; i++) n += (m_cat[r][i] != 0) ? 1 : 0;
            chk("outstanding", 512'(outstanding[r]), 512'(n));
            chk("outstanding_age4", 512'(out4[r]), 512'(n));
        end
        chk("sample_v", 512'(sv), 512'(e_sv));
        chk("sample_v_age4", 512'(sv4), 512'(e_sv));
        for (int p = 0; p < NP; p++)
            if (e_sv[p]) begin
                chk("sample_rf", 512'(srf[p]), 512'(e_rf[p]));
                chk("sample_rd", 512'(srd[p]), 512'(e_rd[p]));
                chk("sample_cat", 512'(scat[p]), 512'(e_cat[p]));
                chk("sample_age", 512'(sage[p]), 512'(e_age[p] > 65535 ? 65535 : e_age[p]));
                chk("sample_age4", 512'(sage4[p]), 512'(e_age[p] > 15 ? 15 : e_age[p]));
            end
        chk("err", 512'(err), 512'(m_err));
        chk("err_age4", 512'(err4), 512'(m_err));
    endtask

    task automatic cyc();
        step_model();
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        reset_n = 1'b1; stall_all = 1'b0; stall_id = 1'b0; flush = 1'b0; issue_v = 1'b0;
        issue_rf = '0; issue_rd = '0; is_long = 1'b0; is_load = 1'b0; is_amo = 1'b0;
        is_seq = 1'b0; addr = '0; clear_v = '0; clear_rf = '0; clear_id = '0;
    endtask

    task automatic issue(input int rf, input int rd, input bit lng, input bit ld, input bit seq,
                         input logic [31:0] a);
        idle();
        issue_v = 1'b1; issue_rf = 1'(rf); issue_rd = 5'(rd);
        is_long = lng; is_load = ld; is_seq = seq; addr = a;
    endtask

    initial begin
        for (int r = 0; r < NRF; r++)
            for (int i = 0; i < NREG; i++) begin
                m_cat[r][i] = 0;
                m_age[r][i] = 0;
            end
        m_err = 1'b0;
        e_sv = '0;
        idle();
        reset_n = 1'b0;
        cyc();
        cyc();
        chk("reset_sb", 512'(sb), 512'(0));
        chk("reset_err", 512'(err), 512'(0));

        // DRAM load x5, clear after 7 cycles pending
        issue(0, 5, 0, 1, 0, 32'h8000_0010);
        cyc();
        chk("dram_set", 512'(sb[0][5]), 512'(6'b000010));
        idle();
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("dram_hold", 512'(sb[0][5]), 512'(6'b000010));
        end
        clear_v = 2'b01; clear_rf[0] = 1'b0; clear_id[0] = 5'd5;
        cyc();
        chk("dram_sv", 512'(sv[0]), 512'(1));
        chk("dram_age", 512'(sage[0]), 512'(7));
        chk("dram_cat", 512'(scat[0]), 512'(6'b000010));
        chk("dram_clr", 512'(sb[0][5]), 512'(0));

        // Global float load held in ID by a stall, then a flushed issue
        issue(1, 3, 0, 1, 0, 32'h4000_0000);
        stall_id = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_noset", 512'(sb[1][3]), 512'(0));
        end
        stall_id = 1'b0;
        cyc();
        chk("global_set", 512'(sb[1][3]), 512'(6'b010000));
        issue(1, 4, 0, 1, 0, 32'h4000_0000);
        flush = 1'b1;
        cyc();
        chk("flush_noset", 512'(sb[1][4]), 512'(0));

        // Long op pending 20 cycles: wide age exact, narrow age saturated
        issue(0, 9, 1, 0, 0, 32'h0);
        cyc();
        idle();
        for (int k = 0; k < 19; k++) cyc();
        clear_v = 2'b01; clear_rf[0] = 1'b0; clear_id[0] = 5'd9;
        cyc();
        chk("sat_age16", 512'(sage[0]), 512'(20));
        chk("sat_age4", 512'(sage4[0]), 512'(15));

        // Same-cycle clear and reissue of x7
        issue(0, 7, 0, 1, 0, 32'h2000_0000);
        cyc();
        idle();
        cyc();
        cyc();
        chk("same_out_before", 512'(outstanding[0]), 512'(1));
        issue(0, 7, 1, 0, 0, 32'h0);
        clear_v = 2'b01; clear_rf[0] = 1'b0; clear_id[0] = 5'd7;
        cyc();
        chk("same_cat_old", 512'(scat[0]), 512'(6'b100000));
        chk("same_age_old", 512'(sage[0]), 512'(3));
        chk("same_new", 512'(sb[0][7]), 512'(6'b000001));
        chk("same_out_after", 512'(outstanding[0]), 512'(1));
        chk("same_noerr", 512'(err), 512'(0));

        // Both ports clear f2 in one cycle
        issue(1, 2, 0, 1, 1, 32'h8000_0000);
        cyc();
        idle();
        clear_v = 2'b11; clear_rf = '{1'b1, 1'b1}; clear_id = '{5'd2, 5'd2};
        cyc();
        chk("dup_sv", 512'(sv), 512'(2'b01));
        chk("dup_cat", 512'(scat[0]), 512'(6'b000100));
        chk("dup_err", 512'(err), 512'(1));
        idle();
        for (int k = 0; k < 3; k++) cyc();
        chk("err_sticky", 512'(err), 512'(1));

        // Fill all int registers, then reset with a clear pending
        idle();
        reset_n = 1'b0;
        cyc();
        for (int i = 0; i < NREG; i++) begin
            issue(0, i, 1, 0, 0, 32'h0);
            cyc();
        end
        chk("fill_out", 512'(outstanding[0]), 512'(32));
        idle();
        reset_n = 1'b0;
        clear_v = 2'b01; clear_rf[0] = 1'b0; clear_id[0] = 5'd0;
        cyc();
        chk("rst_sb", 512'(sb), 512'(0));
        chk("rst_out", 512'(outstanding[0]), 512'(0));
        chk("rst_sv", 512'(sv), 512'(0));

        // Random traffic concentrated on a few registers to provoke collisions
        for (int n = 0; n < 1500; n++) begin
            int t;
            idle();
            reset_n = ($urandom_range(0, 149) != 0);
            stall_all = ($urandom_range(0, 9) == 0);
            stall_id = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            issue_v = ($urandom_range(0, 2) != 0);
            issue_rf = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 5));
            t = $urandom_range(0, 3);
            is_long = (t == 0); is_load = (t == 1); is_amo = (t == 2);
            is_seq = 1'($urandom_range(0, 1));
            addr = $urandom;
            for (int p = 0; p < NP; p++) begin
                clear_v[p] = ($urandom_range(0, 2) == 0);
                clear_rf[p] = 1'($urandom_range(0, 1));
                clear_id[p] = 5'($urandom_range(0, 5));
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
